// File: rtl/txwregif_rd_ctl_if.sv
// Bundle between the TX register-write FIFO read port, the register file write
// port and the status outputs of txwregif_rd_ctl.
interface txwregif_rd_ctl_if #(
  parameter int WIDTH      = 8,
  parameter int DATA_BYTES = 4
);
  logic                        rdempty;
  logic                        rden;
  logic [WIDTH-1:0]            dataout;
  logic                        flush;
  logic                        reg_wr;
  logic [WIDTH-1:0]            reg_addr;
  logic [WIDTH*DATA_BYTES-1:0] reg_wdata;
  logic                        reg_ack;
  logic                        busy;
  logic [15:0]                 cmd_cnt;
  logic                        err;
  logic                        dbg;

  modport slave (
    input  rdempty, dataout, flush, reg_ack,
    output rden, reg_wr, reg_addr, reg_wdata, busy, cmd_cnt, err, dbg
  );

  modport master (
    output rdempty, dataout, flush, reg_ack,
    input  rden, reg_wr, reg_addr, reg_wdata, busy, cmd_cnt, err, dbg
  );
endinterface

// File: rtl/txwregif_rd_ctl.sv
// Read-side controller of the TX register-write FIFO: assembles address + data bytes
// into register writes. Optional ack timeout enabled by TXWREGIF_RD_ACK_TIMEOUT_EN.
module txwregif_rd_ctl #(
  parameter int WIDTH      = 8,
  parameter int DATA_BYTES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic             rdclk,
  input  logic             reset,
  txwregif_rd_ctl_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(DATA_BYTES);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("txwregif_rd_ctl: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {FETCH, CAPT, REQ} state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic [CNT_W-1:0]            byte_cnt;
  logic [WIDTH-1:0]            addr;
  logic [WIDTH*DATA_BYTES-1:0] wdata;
  logic [15:0]                 cnt;
  logic                        err;
  logic                        rden;
  logic                        timeout_hit;

`ifdef TXWREGIF_RD_ACK_TIMEOUT_EN
  localparam int TMR_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TMR_W-1:0] timer;

  // Timer sits at zero outside REQ, so it is already cleared on REQ entry.
  always_ff @(posedge rdclk) begin
    if (reset || state != REQ) timer <= '0;
    else                       timer <= timer + TMR_W'(1);
  end

  assign timeout_hit = (state == REQ) && (timer == TMR_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge rdclk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH:   if (rden) state_nxt = CAPT;
      CAPT:    state_nxt = (!bus.flush && byte_cnt == LAST_BYTE) ? REQ : FETCH;
      REQ:     if (bus.reg_ack || timeout_hit) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    rden          = (state == FETCH) && !bus.rdempty && !bus.flush;
    bus.rden      = rden;
    bus.reg_wr    = (state == REQ);
    bus.dbg       = (state == REQ);
    bus.busy      = (byte_cnt != '0) || (state != FETCH);
    bus.reg_addr  = addr;
    bus.reg_wdata = wdata;
    bus.cmd_cnt   = cnt;
    bus.err       = err;
  end

  // Byte assembly, completion counting and sticky error; flush never disturbs REQ.
  always_ff @(posedge rdclk) begin
    if (reset) begin
      byte_cnt <= '0;
      addr     <= '0;
      wdata    <= '0;
      cnt      <= '0;
      err      <= 1'b0;
    end else begin
      if (bus.flush && state != REQ) begin
        byte_cnt <= '0;
        if (byte_cnt != '0) err <= 1'b1;
      end else if (state == CAPT) begin
        if (byte_cnt == '0) addr <= bus.dataout;
        for (int k = 1; k <= DATA_BYTES; k++) begin
          if (int'(byte_cnt) == k) wdata[k*WIDTH-1 -: WIDTH] <= bus.dataout;
        end
        byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + CNT_W'(1);
      end

      if (state == REQ) begin
        if (bus.reg_ack)      cnt <= cnt + 16'd1;
        else if (timeout_hit) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_txwregif_rd_ctl.sv
// Scoreboard bench for txwregif_rd_ctl: a FIFO model feeds bytes, an ack process
// answers writes, and a monitor pops expected writes whenever reg_wr rises.
module tb_txwregif_rd_ctl;
  localparam int WIDTH = 8;
  localparam int DB    = 4;
  localparam int NEVER = 100000;
`ifdef TXWREGIF_RD_ACK_TIMEOUT_EN
  localparam int TMO = 10;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  txwregif_rd_ctl_if #(.WIDTH(WIDTH), .DATA_BYTES(DB)) ifc ();

  txwregif_rd_ctl #(.WIDTH(WIDTH), .DATA_BYTES(DB), .TIMEOUT(TMO)) dut (
    .rdclk (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic        gap = 1'b0;
  int          ack_delay = 1;
  int          last_wr_len = 0;
  logic        s_rden;
  logic        s_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    ifc.rdempty = gap || (fifo_q.size() == 0);
  endtask

  // One clock: sample at negedge, then service the FIFO pop just after the rising edge.
  task automatic step();
    logic pop;
    @(negedge clk);
    pop    = ifc.rden;
    s_rden = ifc.rden;
    s_busy = ifc.busy;
    @(posedge clk);
    #1;
    if (pop && fifo_q.size() > 0) ifc.dataout = fifo_q.pop_front();
    refresh();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh();
  endtask

  task automatic send(input logic [7:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
    push_byte(a);
    for (int i = 0; i < DB; i++) push_byte(d[i*8 +: 8]);
  endtask

  task automatic do_reset();
    fifo_q.delete();
    gap   = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    refresh();
  endtask

  // Register file model: ack ack_delay cycles after reg_wr rises.
  initial begin
    int age;
    age = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ifc.reg_wr) begin
        ifc.reg_ack = (age == ack_delay);
        age++;
      end else begin
        ifc.reg_ack = 1'b0;
        age = 0;
      end
    end
  end

  // Monitor: scoreboard pop on each write, hold checks, write length, FIFO underrun.
  initial begin
    logic        prev;
    int          cur_len;
    logic [7:0]  held_a;
    logic [31:0] held_d;
    prev    = 1'b0;
    cur_len = 0;
    forever begin
      @(negedge clk);
      if (ifc.reg_wr && !prev) begin
        held_a = ifc.reg_addr;
        held_d = ifc.reg_wdata;
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write addr=0x%0h data=0x%0h required=none", ifc.reg_addr, ifc.reg_wdata);
        end else begin
          chk("wr_addr", ifc.reg_addr, exp_addr_q.pop_front());
          chk("wr_data", ifc.reg_wdata, exp_data_q.pop_front());
        end
      end else if (ifc.reg_wr && prev) begin
        chk("hold_addr", ifc.reg_addr, held_a);
        chk("hold_data", ifc.reg_wdata, held_d);
      end
      if (ifc.reg_wr) cur_len++;
      else if (prev) begin
        last_wr_len = cur_len;
        cur_len     = 0;
      end
      if (ifc.rden) chk("rden_while_empty", ifc.rdempty, 1'b0);
      prev = ifc.reg_wr;
    end
  end

  initial begin
    int n;
    reset       = 1'b1;
    ifc.flush   = 1'b0;
    ifc.reg_ack = 1'b0;
    ifc.dataout = '0;
    ifc.rdempty = 1'b1;
    run(2);
    chk("rst_reg_wr", ifc.reg_wr, 1'b0);
    chk("rst_reg_addr", ifc.reg_addr, 8'h00);
    chk("rst_reg_wdata", ifc.reg_wdata, 32'h0);
    chk("rst_cmd_cnt", ifc.cmd_cnt, 16'h0);
    chk("rst_err", ifc.err, 1'b0);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_dbg", ifc.dbg, 1'b0);
    reset = 1'b0;
    refresh();

    // Basic command, ack one cycle after reg_wr
    ack_delay = 1;
    send(8'h10, 32'h11223344);
    run(20);
    chk("t1_cmd_cnt", ifc.cmd_cnt, 16'd1);
    chk("t1_err", ifc.err, 1'b0);
    chk("t1_wr_len", last_wr_len, 2);
    chk("t1_busy", ifc.busy, 1'b0);

    // FIFO empty gap between bytes 2 and 3
    exp_addr_q.push_back(8'h10);
    exp_data_q.push_back(32'h11223344);
    push_byte(8'h10);
    push_byte(8'h44);
    run(4);
    gap = 1'b1;
    push_byte(8'h33);
    push_byte(8'h22);
    push_byte(8'h11);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t2_gap_rden", s_rden, 1'b0);
      chk("t2_gap_busy", s_busy, 1'b1);
    end
    gap = 1'b0;
    refresh();
    run(20);
    chk("t2_cmd_cnt", ifc.cmd_cnt, 16'd2);
    chk("t2_err", ifc.err, 1'b0);
    chk("t2_wr_len", last_wr_len, 2);

    // Flush after two bytes, then a full command
    do_reset();
    push_byte(8'h99);
    push_byte(8'h01);
    run(4);
    chk("t3_busy_partial", ifc.busy, 1'b1);
    ifc.flush = 1'b1;
    step();
    ifc.flush = 1'b0;
    chk("t3_err_after_flush", ifc.err, 1'b1);
    chk("t3_busy_after_flush", ifc.busy, 1'b0);
    send(8'h20, 32'hDDCCBBAA);
    run(20);
    chk("t3_cmd_cnt", ifc.cmd_cnt, 16'd1);
    chk("t3_err_sticky", ifc.err, 1'b1);

    // Ack in the same cycle reg_wr rises: one-cycle write
    ack_delay = 0;
    send(8'h5A, 32'hCAFEF00D);
    run(20);
    chk("t4_wr_len", last_wr_len, 1);
    chk("t4_cmd_cnt", ifc.cmd_cnt, 16'd2);

    // Counter wrap from 0xFFFF
    ack_delay = 1;
    force dut.cnt = 16'hFFFF;
    #1;
    release dut.cnt;
    send(8'h7E, 32'h01020304);
    run(20);
    chk("t5_cmd_cnt_wrap", ifc.cmd_cnt, 16'h0000);

    // Reset while a write is pending
    do_reset();
    ack_delay = NEVER;
    send(8'h33, 32'h0BADBEEF);
    n = 0;
    while (!ifc.reg_wr && n < 40) begin
      step();
      n++;
    end
    chk("t6_req_reached", ifc.reg_wr, 1'b1);
    chk("t6_dbg_in_req", ifc.dbg, 1'b1);
    step();
    do_reset();
    chk("t6_reg_wr", ifc.reg_wr, 1'b0);
    chk("t6_busy", ifc.busy, 1'b0);
    chk("t6_dbg", ifc.dbg, 1'b0);
    chk("t6_cmd_cnt", ifc.cmd_cnt, 16'd0);

    // Reset mid-command discards the partial bytes
    ack_delay = 1;
    push_byte(8'h01);
    push_byte(8'h02);
    run(4);
    do_reset();
    send(8'h44, 32'h55667788);
    run(20);
    chk("t7_cmd_cnt", ifc.cmd_cnt, 16'd1);
    chk("t7_err", ifc.err, 1'b0);

`ifdef TXWREGIF_RD_ACK_TIMEOUT_EN
    ack_delay = NEVER;
    send(8'h61, 32'h12345678);
    run(30);
    chk("t8_wr_len", last_wr_len, TMO);
    chk("t8_err", ifc.err, 1'b1);
    chk("t8_cmd_cnt", ifc.cmd_cnt, 16'd1);
    ack_delay = 1;
    send(8'h62, 32'h9ABCDEF0);
    run(20);
    chk("t8_next_cmd_cnt", ifc.cmd_cnt, 16'd2);
    chk("t8_next_wr_len", last_wr_len, 2);
`endif

    chk("scoreboard_drained", exp_addr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/txwregif_rd_ctl.md
Name: txwregif_rd_ctl

Overview:
- Read-side controller for the TX register-write FIFO; runs in the FIFO read clock domain.
- Pops bytes from the FIFO read port and assembles each command from 1 address byte followed by DATA_BYTES data bytes, little-endian.
- Issues one register write per command over a req/ack handshake to the register file.
- Counts completed writes and flags malformed or stalled transactions.

Parameters:
- WIDTH, 8, FIFO byte width; address width equals WIDTH.
- DATA_BYTES, 4, data bytes per command; reg_wdata width = WIDTH*DATA_BYTES.
- TIMEOUT, 255, ack timeout in cycles; used only with the optional feature.

Ports:
- rdclk  in  1  FIFO read clock; all logic on rising edge.
- reset  in  1  synchronous active-high reset.
- rdempty  in  1  FIFO empty flag.
- rden  out  1  FIFO pop request; combinational.
- dataout  in  WIDTH  FIFO read data; valid the cycle after rden.
- flush  in  1  synchronous abort of a partial command.
- reg_wr  out  1  register write request.
- reg_addr  out  WIDTH  write address.
- reg_wdata  out  WIDTH*DATA_BYTES  write data.
- reg_ack  in  1  write accepted.
- busy  out  1  command in progress.
- cmd_cnt  out  16  completed-write counter.
- err  out  1  sticky error flag.
- dbg  out  1  high while in REQ state.

Behaviour:
- Reset values: state=FETCH, byte_cnt=0, reg_wr=0, reg_addr=0, reg_wdata=0, cmd_cnt=0, err=0, busy=0.
- Reset mid-command discards all captured bytes.
- States:
  - FETCH: rden = (state==FETCH) & !rdempty & !flush. If rden is high, go to CAPT; otherwise stay.
  - CAPT: capture dataout. byte_cnt=0 loads reg_addr. byte_cnt=k (k≥1) loads reg_wdata[k*WIDTH-1 -: WIDTH].
    - If byte_cnt==DATA_BYTES: byte_cnt←0, reg_wr←1, go to REQ.
    - Otherwise: byte_cnt++, go to FETCH.
  - REQ: reg_wr, reg_addr and reg_wdata are held stable.
    - On reg_ack=1: reg_wr←0, cmd_cnt++ (wraps 0xFFFF→0), go to FETCH.
    - An ack arriving in the same cycle that reg_wr rises is honoured on the next edge. reg_wr is high for at least 1 cycle.
- Throughput: 2 cycles per byte, plus 1 or more cycles in REQ. Minimum command time = 2*(DATA_BYTES+1)+1 cycles.
- busy = (byte_cnt!=0) | (state!=FETCH).
- rden is never asserted while rdempty=1.
- rdempty during FETCH simply stalls; no timeout applies to FIFO underrun.
- flush:
  - In FETCH or CAPT: byte_cnt←0, state←FETCH, captured bytes dropped. err is set if byte_cnt≠0 (partial command).
  - In REQ: ignored; the handshake must complete.
- reg_ack outside REQ is ignored.
- err is cleared only by reset.
- reg_addr and reg_wdata keep their last values after completion. They are undefined to the consumer unless reg_wr=1.

Optional Feature:
- Macro: TXWREGIF_RD_ACK_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider timer counts REQ cycles, cleared on entry to REQ.
  - If it reaches TIMEOUT without reg_ack: reg_wr←0, err←1, go to FETCH, cmd_cnt unchanged.
  - An ack on the timeout cycle wins: counted, no error.
- Not defined: REQ waits indefinitely for reg_ack; no timer logic is present.

Test Plan:
- Reset, then FIFO bytes 0x10,0x44,0x33,0x22,0x11, ack 1 cycle after reg_wr → reg_addr=0x10, reg_wdata=0x11223344, reg_wr high for 2 cycles, cmd_cnt=1, err=0.
- Same 5 bytes with rdempty=1 for 6 cycles between bytes 2 and 3 → rden low throughout the gap, result identical, busy high throughout.
- flush after 2 bytes, then a full command 0x20,0xAA,0xBB,0xCC,0xDD → err=1, single write to addr 0x20 with data 0xDDCCBBAA, cmd_cnt=1.
- Preload cmd_cnt to 0xFFFF via 65535 back-to-back commands (or force), one more command → cmd_cnt=0x0000.
- reset asserted in REQ with reg_wr=1 → next cycle reg_wr=0, state FETCH, byte_cnt=0, cmd_cnt=0.
- TXWREGIF_RD_ACK_TIMEOUT_EN defined, TIMEOUT=10, reg_ack held low → reg_wr drops after 10 REQ cycles, err=1, cmd_cnt unchanged. The next command completes normally.
